// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers.
// Used by the oversampling receiver and tick generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int OS_RATE = 16;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: one pulse every OS_DIV clocks while enabled.
// Held at zero when disabled so each enable starts a fresh period.
module uart_os_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic os_tick
);

  localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * OS_RATE);
  localparam int CW = (OS_DIV < 2) ? 1 : $clog2(OS_DIV);
  localparam logic [CW-1:0] LAST = CW'(OS_DIV - 1);

  generate
    if (OS_DIV < 2) begin : g_bad_div
      $error("uart_os_tick_gen: OS_DIV must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign os_tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority vote, parity/frame
// checks, break detection and a ready/valid output with overrun pulse.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
      $error("uart_rx_os: PARITY_MODE must be 0..2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_rx_os: SYNC_STAGES must be at least 2");
    end
  endgenerate

  uart_rx_state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   os_tick;
  logic                   tick_en;
  logic [3:0]             os_cnt;
  logic [3:0]             bit_cnt;
  logic                   s7, s8;
  logic                   bit_val;
  logic                   at_dec;
  logic                   at_wrap;
  logic                   frame_end;
  logic                   par_calc;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   frm_q;
  logic                   stop0_q;
  logic                   done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_os_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (tick_en),
    .os_tick(os_tick)
  );

  // Vote uses the two stored samples plus the live one at os_cnt 9.
  assign at_dec   = os_tick && (os_cnt == 4'd9);
  assign at_wrap  = os_tick && (os_cnt == 4'd15);
  assign bit_val  = maj3(s7, s8, rx_s);
  assign par_calc = (^shift_q) ^ (PARITY_MODE == PARITY_ODD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_nx = START;
      end
      START: begin
        if (at_dec && bit_val) state_nx = IDLE;
        else if (at_wrap) state_nx = DATA;
      end
      DATA: begin
        if (at_wrap && bit_cnt == LAST_DATA)
          state_nx = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
      end
      PARITY: begin
        if (at_wrap) state_nx = STOP;
      end
      STOP: begin
        if (frame_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    tick_en   = (state != IDLE);
    frame_end = (state == STOP) && at_dec && (bit_cnt == LAST_STOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      s7      <= 1'b0;
      s8      <= 1'b0;
    end else begin
      if (state == IDLE) os_cnt <= '0;
      else if (os_tick) os_cnt <= os_cnt + 4'd1;
      if (os_tick && os_cnt == 4'd7) s7 <= rx_s;
      if (os_tick && os_cnt == 4'd8) s8 <= rx_s;
      if (state == IDLE || state == START) begin
        bit_cnt <= '0;
      end else if (at_wrap) begin
        if ((state == DATA && bit_cnt != LAST_DATA) || state == STOP)
          bit_cnt <= bit_cnt + 4'd1;
        else
          bit_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
      stop0_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (state == START) begin
        shift_q <= '0;
        par_q   <= 1'b0;
        frm_q   <= 1'b0;
        stop0_q <= 1'b0;
      end else if (at_dec) begin
        unique case (1'b1)
          state == DATA: begin
            shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
          end
          state == PARITY: begin
            par_q <= (par_calc != bit_val);
          end
          state == STOP: begin
            if (!bit_val) frm_q <= 1'b1;
            if (bit_cnt == 4'd0) stop0_q <= !bit_val;
          end
          default: ;
        endcase
      end
    end
  end

  // A completed frame only lands if the holding register is free
  // or being drained in the same cycle; otherwise it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun   <= done_q && data_valid && !data_ready;
      break_det <= done_q && (shift_q == '0) && stop0_q;
      if (done_q && (!data_valid || data_ready)) begin
        data_out   <= shift_q;
        parity_err <= par_q;
        frame_err  <= frm_q;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
